mu0_flags_reg: RTL
==================

# mu0_flags_reg

Registered, parametrised condition-flag unit for the MU0-family datapath. Captures N, Z, C and V from the ALU result on an update strobe and keeps a small LIFO of saved flag sets for interrupt entry and exit. Also evaluates a 3-bit branch condition against the held flags. Sits between the ALU/accumulator and the control FSM, replacing the purely combinational N/Z decode.

## Interface
- WIDTH, 16: data width of the ALU result; must be ≥ 2.
- STACK_DEPTH, 4: number of saved flag sets; must be ≥ 1.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- result  input  WIDTH  ALU result to be flagged.
- carry_in  input  1  ALU carry/borrow out.
- ovf_in  input  1  ALU signed overflow.
- update  input  1  load N/Z/C/V from result/carry_in/ovf_in.
- flags_wr  input  1  direct write of the flags from flags_wdata.
- flags_wdata  input  4  {N,Z,C,V} for flags_wr.
- save  input  1  push the current flags onto the stack.
- restore  input  1  pop the stack into the flags.
- clear_err  input  1  clear stack_err.
- cond  input  3  branch condition select.
- cond_true  output  1  selected condition holds on the registered flags.
- N, Z, C, V  output  1 each  registered flags.
- stack_full, stack_empty  output  1 each  stack status.
- stack_err  output  1  sticky: push on full or pop on empty.

## Operation
- Decode on update:
  - N = result[WIDTH-1].
  - Z = (result == 0).
  - C = carry_in.
  - V = ovf_in.
- Flag register source, in priority order:
  1. restore with a non-empty stack loads the top entry.
  2. Otherwise flags_wr loads flags_wdata.
  3. Otherwise update loads the decoded values.
  4. Otherwise the flags hold.
- Stack:
  - save pushes the pre-edge flags, i.e. the value before any same-cycle update or write.
  - save while full: entry discarded, stack unchanged, stack_err set.
  - restore while empty: flags follow the remaining priority chain, stack_err set.
  - save and restore in the same cycle: no stack change and no error. The flags follow flags_wr/update only.
  - stack_full = (count == STACK_DEPTH); stack_empty = (count == 0).
- stack_err is sticky until clear_err or reset. If clear_err and a new error occur in the same cycle, the error wins.
- cond encoding, combinational on the registered flags:
  - 0: always
  - 1: Z (eq)
  - 2: ~Z (ne)
  - 3: ~N (MU0 JGE)
  - 4: N
  - 5: C
  - 6: V
  - 7: ~Z & ~N (gt)

## Timing
- Reset values: N=0, Z=1, C=0, V=0, count=0, stack_empty=1, stack_full=0, stack_err=0, cond_true=1 (cond=0).
- Reset is asynchronous assert and synchronous-safe deassert. Reset asserted mid-operation clears the flags and the stack immediately.
- All registered outputs change only on the rising edge of clk.
- Latency:
  - update, flags_wr and restore are visible on N/Z/C/V one cycle after the strobe edge.
  - cond_true follows in the same cycle, with no bypass from result.
- Stack status and stack_err update on the same edge as the push or pop.
- A save immediately followed by a restore on consecutive cycles returns the saved set, with any intervening update discarded.

## Configuration
- MU0_FLAGS_STICKY_V_EN defined:
  - V is sticky: update sets V when ovf_in=1 and never clears it.
  - V clears only through flags_wr, restore or reset.
- MU0_FLAGS_STICKY_V_EN undefined: V follows ovf_in on every update.

## Test plan
- Reset then idle: N=0, Z=1, C=0, V=0, stack_empty=1, stack_err=0; cond=0 gives cond_true=1, cond=2 gives 0.
- WIDTH=16, update with result=16'h8000, carry_in=1, ovf_in=0: next cycle N=1, Z=0, C=1, V=0; cond=4 gives 1, cond=3 gives 0, cond=7 gives 0.
- Three steps:
  - Flags N=1 (result=16'h8000), then save together with update on result=16'h0000: next cycle Z=1, N=0.
  - Restore: next cycle N=1, Z=0.
  - stack_empty=1 again.
- STACK_DEPTH=4: five saves give stack_full=1 after the fourth and stack_err=1 after the fifth. Four restores return entries in LIFO order. A fifth restore leaves the flags unchanged with stack_err still 1. clear_err then gives 0.
- update with ovf_in=1 then update with ovf_in=0:
  - With MU0_FLAGS_STICKY_V_EN, V stays 1 until flags_wr with 4'b0100, which gives V=0, Z=1.
  - Without the macro, V=0 after the second update.
- flags_wr=4'b1010 during an active update, then reset_n pulsed low mid-cycle: flags_wr wins (N=1, C=1). The asynchronous reset returns all outputs to reset values before the next edge.

Source files
------------

// File: rtl/mu0_flags_reg.sv
// MU0 condition-flag register: N/Z/C/V capture, LIFO save/restore stack and branch-condition evaluation.
// Optional build macro MU0_FLAGS_STICKY_V_EN makes V sticky across updates.
module mu0_flags_reg #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] result,
    input  logic             carry_in,
    input  logic             ovf_in,
    input  logic             update,
    input  logic             flags_wr,
    input  logic [3:0]       flags_wdata,
    input  logic             save,
    input  logic             restore,
    input  logic             clear_err,
    input  logic [2:0]       cond,
    output logic             cond_true,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_err
);

    localparam int unsigned CW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(STACK_DEPTH);
    localparam logic [3:0]    FLAGS_RST = 4'b0100;

    logic [3:0]    flags_q, flags_d;
    logic [3:0]    stack_q [STACK_DEPTH];
    logic [3:0]    stack_d [STACK_DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    logic          push, pop, full, empty, new_err, v_dec;
    logic [IW-1:0] wr_idx, top_idx;
    logic [3:0]    decoded;

    // Stack status and ALU decode; simultaneous save+restore cancels out.
    always_comb begin
        full    = (count_q == DEPTH_C);
        empty   = (count_q == '0);
        push    = save & ~restore;
        pop     = restore & ~save;
        wr_idx  = IW'(count_q);
        top_idx = IW'(count_q - CW'(1));
`ifdef MU0_FLAGS_STICKY_V_EN
        v_dec   = flags_q[0] | ovf_in;
`else
        v_dec   = ovf_in;
`endif
        decoded = {result[WIDTH-1], (result == '0), carry_in, v_dec};
    end

    // Next-state: restore > flags_wr > update > hold; push stores the pre-edge flags.
    always_comb begin
        flags_d = flags_q;
        stack_d = stack_q;
        count_d = count_q;
        new_err = (push & full) | (pop & empty);

        if (pop && !empty) begin
            flags_d = stack_q[top_idx];
            count_d = count_q - CW'(1);
        end else if (flags_wr) begin
            flags_d = flags_wdata;
        end else if (update) begin
            flags_d = decoded;
        end

        if (push && !full) begin
            stack_d[wr_idx] = flags_q;
            count_d         = count_q + CW'(1);
        end

        if (new_err) begin
            err_d = 1'b1;
        end else if (clear_err) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= FLAGS_RST;
            count_q <= '0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            flags_q <= flags_d;
            count_q <= count_d;
            err_q   <= err_d;
            stack_q <= stack_d;
        end
    end

    always_comb begin
        N           = flags_q[3];
        Z           = flags_q[2];
        C           = flags_q[1];
        V           = flags_q[0];
        stack_full  = full;
        stack_empty = empty;
        stack_err   = err_q;
    end

    // Branch condition on the held flags only.
    always_comb begin
        cond_true = 1'b1;
        case (cond)
            3'd0:    cond_true = 1'b1;
            3'd1:    cond_true = flags_q[2];
            3'd2:    cond_true = ~flags_q[2];
            3'd3:    cond_true = ~flags_q[3];
            3'd4:    cond_true = flags_q[3];
            3'd5:    cond_true = flags_q[1];
            3'd6:    cond_true = flags_q[0];
            default: cond_true = ~flags_q[2] & ~flags_q[3];
        endcase
    end

endmodule
